// File: rtl/dsram_arbiter_pkg.sv
// Shared widths, port indices and defaults for the data-SRAM arbiter.
package dsram_arbiter_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int WEN_W          = 4;
  localparam int PORT0          = 0;
  localparam int PORT1          = 1;
  localparam int WAIT_LIMIT_DEF = 4;

  // One-hot grant encoding produced by the picker.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_P0   = 2'b01,
    GNT_P1   = 2'b10
  } gnt_e;

  // Width of a counter that must hold 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dsram_arbiter_if.sv
// Request/grant/return bundle for the two requesters sharing the data SRAM.
interface dsram_arbiter_if;
  import dsram_arbiter_pkg::*;

  logic              p0_req;
  logic [WEN_W-1:0]  p0_wen;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic [WEN_W-1:0]  p1_wen;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  // Requester side.
  modport master (
    output p0_req, p0_wen, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_wen, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata
  );

  // Arbiter side.
  modport slave (
    input  p0_req, p0_wen, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_wen, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata
  );

endinterface

// File: rtl/dsram_rr_pick.sv
// Two-input grant picker: single requester always wins; on contention
// force1 selects port 1, otherwise prio picks the preferred port.
module dsram_rr_pick
  import dsram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       force1,
  output logic [1:0] gnt
);

  // Resolve the one-hot grant from the request pair.
  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_P0;
      2'b10:   gnt = GNT_P1;
      2'b11:   gnt = (force1 || prio) ? GNT_P1 : GNT_P0;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/dsram_arbiter.sv
// Arbiter for two requesters sharing one synchronous data SRAM. Grants are
// combinational; read data returns one cycle later to the owning port.
module dsram_arbiter
  import dsram_arbiter_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter bit RR_EN      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  dsram_arbiter_if.slave    bus,
  output logic              data_sram_en,
  output logic [WEN_W-1:0]  data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq
);

  localparam int              CNT_W = cnt_width(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  // Saturating increment for the p1 starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
  endfunction

  logic             prio_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             vld_p1;
  logic             rd_owner_p1;
  logic             kill_p1;

  logic [1:0] req;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic       prio_eff;
  logic       force1;
  logic       rd_gnt;

  assign req      = {bus.p1_req, bus.p0_req};
  assign prio_eff = RR_EN ? prio_q : 1'b0;
  assign force1   = !RR_EN && (wait_cnt_q == LIMIT);

  dsram_rr_pick u_pick (
    .req    (req),
    .prio   (prio_eff),
    .force1 (force1),
    .gnt    (pick)
  );

  // ---- stage p0: grant and SRAM issue ----
  // Reset forces every grant low regardless of requests.
  assign gnt        = pick & {2{rst}};
  assign bus.p0_gnt = gnt[PORT0];
  assign bus.p1_gnt = gnt[PORT1];
  assign stallreq   = rst && bus.p0_req && !gnt[PORT0];
  assign rd_gnt     = (gnt[PORT0] && (bus.p0_wen == '0)) ||
                      (gnt[PORT1] && (bus.p1_wen == '0));

  // Drive the SRAM from whichever port holds the grant, zero when idle.
  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (gnt[PORT0]) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = bus.p0_wen;
      data_sram_addr  = bus.p0_addr;
      data_sram_wdata = bus.p0_wdata;
    end else if (gnt[PORT1]) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = bus.p1_wen;
      data_sram_addr  = bus.p1_addr;
      data_sram_wdata = bus.p1_wdata;
    end
  end

  // Arbitration state: round-robin pointer and p1 starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      // After a grant the pointer prefers the port that lost.
      if (RR_EN && (gnt != 2'b00)) prio_q <= gnt[PORT0];
      if (!RR_EN) begin
        if (gnt[PORT1] || !bus.p1_req) wait_cnt_q <= '0;
        else                           wait_cnt_q <= sat_inc(wait_cnt_q);
      end
    end
  end

  // Track the read issued this cycle so its data can be steered next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      rd_owner_p1 <= 1'b0;
      kill_p1     <= 1'b0;
    end else begin
      vld_p1      <= rd_gnt;
      rd_owner_p1 <= gnt[PORT1];
      kill_p1     <= flush && gnt[PORT0];
    end
  end

  // ---- stage p1: read return ----
  // A flush in either the issue or return cycle squashes p0 data only.
  assign bus.p0_rvalid = rst && vld_p1 && !rd_owner_p1 && !flush && !kill_p1;
  assign bus.p1_rvalid = rst && vld_p1 && rd_owner_p1;
  assign bus.p0_rdata  = data_sram_rdata;
  assign bus.p1_rdata  = data_sram_rdata;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Bench for dsram_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus; each has its own SRAM and its own reference model.
`timescale 1ns/1ps
module tb_dsram_arbiter;
  import dsram_arbiter_pkg::*;

  localparam int WL = 4;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic flush    = 1'b0;
  logic mem_init = 1'b1;

  logic        r0 = 1'b0, r1 = 1'b0;
  logic [3:0]  w0 = '0, w1 = '0;
  logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;

  int checks = 0;
  int errors = 0;

  dsram_arbiter_if bus_rr ();
  dsram_arbiter_if bus_fx ();

  logic [1:0]       s_en;
  logic [1:0][3:0]  s_wen;
  logic [1:0][31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]       stall;
  logic [1:0]       g0, g1, v0, v1;
  logic [1:0][31:0] rd0, rd1;

  assign bus_rr.p0_req = r0;  assign bus_fx.p0_req = r0;
  assign bus_rr.p0_wen = w0;  assign bus_fx.p0_wen = w0;
  assign bus_rr.p0_addr = a0; assign bus_fx.p0_addr = a0;
  assign bus_rr.p0_wdata = d0; assign bus_fx.p0_wdata = d0;
  assign bus_rr.p1_req = r1;  assign bus_fx.p1_req = r1;
  assign bus_rr.p1_wen = w1;  assign bus_fx.p1_wen = w1;
  assign bus_rr.p1_addr = a1; assign bus_fx.p1_addr = a1;
  assign bus_rr.p1_wdata = d1; assign bus_fx.p1_wdata = d1;

  assign g0  = {bus_fx.p0_gnt, bus_rr.p0_gnt};
  assign g1  = {bus_fx.p1_gnt, bus_rr.p1_gnt};
  assign v0  = {bus_fx.p0_rvalid, bus_rr.p0_rvalid};
  assign v1  = {bus_fx.p1_rvalid, bus_rr.p1_rvalid};
  assign rd0 = {bus_fx.p0_rdata, bus_rr.p0_rdata};
  assign rd1 = {bus_fx.p1_rdata, bus_rr.p1_rdata};

  dsram_arbiter #(.WAIT_LIMIT(WL), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_rr),
    .data_sram_en(s_en[0]), .data_sram_wen(s_wen[0]),
    .data_sram_addr(s_addr[0]), .data_sram_wdata(s_wdata[0]),
    .data_sram_rdata(s_rdata[0]), .stallreq(stall[0])
  );

  dsram_arbiter #(.WAIT_LIMIT(WL), .RR_EN(1'b0)) u_fx (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_fx),
    .data_sram_en(s_en[1]), .data_sram_wen(s_wen[1]),
    .data_sram_addr(s_addr[1]), .data_sram_wdata(s_wdata[1]),
    .data_sram_rdata(s_rdata[1]), .stallreq(stall[1])
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 + 32'(i);
  endfunction

  // Synchronous SRAM per instance, preloaded with pat(word index).
  logic [31:0] mem [2][256];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= pat(i);
      end else if (s_en[k]) begin
        if (s_wen[k] == 4'b0000) s_rdata[k] <= mem[k][s_addr[k][9:2]];
        else
          for (int b = 0; b < 4; b++)
            if (s_wen[k][b]) mem[k][s_addr[k][9:2]][8*b +: 8] <= s_wdata[k][8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%s] got %h want %h at %0t", nm, (k == 0) ? "rr" : "fx", act, exp, $time);
    end
  endtask

  // Reference model: per instance, grant decision from the arbitration
  // rules, a one-slot expected return, and a shadow copy of memory.
  int          m_prio [2];
  int          m_wait [2];
  bit          m_pend [2];
  int          m_owner[2];
  bit          m_kill [2];
  logic [31:0] m_rexp [2];
  logic [31:0] shadow [2][256];

  initial begin : model
    int          win;
    bit          ev0, ev1;
    logic [3:0]  ew;
    logic [31:0] ea, ed;
    for (int k = 0; k < 2; k++) begin
      m_prio[k] = 0; m_wait[k] = 0; m_pend[k] = 0; m_owner[k] = 0; m_kill[k] = 0; m_rexp[k] = '0;
      for (int i = 0; i < 256; i++) shadow[k][i] = pat(i);
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst !== 1'b1) begin
          m_prio[k] = 0; m_wait[k] = 0; m_pend[k] = 0; m_kill[k] = 0;
          chk("rst_gnt0", k, g0[k], 0);
          chk("rst_gnt1", k, g1[k], 0);
          chk("rst_rvalid0", k, v0[k], 0);
          chk("rst_rvalid1", k, v1[k], 0);
          chk("rst_en", k, s_en[k], 0);
          chk("rst_wen", k, s_wen[k], 0);
          chk("rst_stall", k, stall[k], 0);
        end else begin
          if (r0 && r1) win = (k == 0) ? m_prio[k] : ((m_wait[k] == WL) ? 1 : 0);
          else if (r0)  win = 0;
          else if (r1)  win = 1;
          else          win = -1;
          ew = '0; ea = '0; ed = '0;
          if (win == 0) begin ew = w0; ea = a0; ed = d0; end
          if (win == 1) begin ew = w1; ea = a1; ed = d1; end
          chk("gnt0", k, g0[k], (win == 0) ? 1 : 0);
          chk("gnt1", k, g1[k], (win == 1) ? 1 : 0);
          chk("sram_en", k, s_en[k], (win >= 0) ? 1 : 0);
          chk("sram_wen", k, s_wen[k], ew);
          chk("sram_addr", k, s_addr[k], ea);
          chk("sram_wdata", k, s_wdata[k], ed);
          chk("stallreq", k, stall[k], (r0 && win != 0) ? 1 : 0);
          ev0 = m_pend[k] && m_owner[k] == 0 && !flush && !m_kill[k];
          ev1 = m_pend[k] && m_owner[k] == 1;
          chk("rvalid0", k, v0[k], ev0);
          chk("rvalid1", k, v1[k], ev1);
          if (ev0) chk("rdata0", k, rd0[k], m_rexp[k]);
          if (ev1) chk("rdata1", k, rd1[k], m_rexp[k]);
          // state for the next cycle
          if (win >= 0 && ew == 4'b0000) begin
            m_pend[k] = 1; m_owner[k] = win; m_rexp[k] = shadow[k][ea[9:2]];
            m_kill[k] = flush && (win == 0);
          end else begin
            m_pend[k] = 0; m_kill[k] = 0;
          end
          if (win >= 0 && ew != 4'b0000)
            for (int b = 0; b < 4; b++)
              if (ew[b]) shadow[k][ea[9:2]][8*b +: 8] = ed[8*b +: 8];
          if (k == 0) begin
            if (win >= 0) m_prio[k] = 1 - win;
          end else begin
            if (!r1 || win == 1) m_wait[k] = 0;
            else if (m_wait[k] < WL) m_wait[k] = m_wait[k] + 1;
          end
        end
      end
    end
  end

  task automatic setp0(input logic q, input logic [3:0] we, input logic [31:0] ad, input logic [31:0] dt);
    r0 = q; w0 = we; a0 = ad; d0 = dt;
  endtask
  task automatic setp1(input logic q, input logic [3:0] we, input logic [31:0] ad, input logic [31:0] dt);
    r1 = q; w1 = we; a1 = ad; d1 = dt;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic adv();
    @(posedge clk); #1;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin : drive
    logic [7:0] h;
    // requests held high during reset: outputs must stay forced low
    setp0(1, 4'h0, 32'h100, 0); setp1(1, 4'h0, 32'h104, 0);
    mid();
    chk("lit_rst_gnt0", 0, g0[0], 0);
    chk("lit_rst_stall", 0, stall[0], 0);
    chk("lit_rst_en", 1, s_en[1], 0);
    adv();
    mem_init = 1'b0;
    rst = 1'b1;

    // contention: rr alternates p0,p1,...; fixed gives p1 only in cycle 5
    for (int c = 1; c <= 6; c++) begin
      mid();
      chk("lit_rr_gnt0", 0, g0[0], (c % 2 == 1) ? 1 : 0);
      chk("lit_rr_gnt1", 0, g1[0], (c % 2 == 0) ? 1 : 0);
      chk("lit_rr_stall", 0, stall[0], (c % 2 == 0) ? 1 : 0);
      chk("lit_fx_gnt1", 1, g1[1], (c == 5) ? 1 : 0);
      adv();
    end
    setp0(0, 0, 0, 0); setp1(0, 0, 0, 0);
    mid();
    chk("lit_rr_ret_p1", 0, v1[0], 1);
    chk("lit_fx_ret_p0", 1, v0[1], 1);
    adv();

    // lone p0 read of 0x100 (word 0x40)
    setp0(1, 4'h0, 32'h100, 0);
    mid();
    chk("lit_lone_gnt0", 0, g0[0], 1);
    chk("lit_lone_gnt0", 1, g0[1], 1);
    adv();
    setp0(0, 0, 0, 0);
    mid();
    chk("lit_lone_rvalid", 0, v0[0], 1);
    chk("lit_lone_rdata", 0, rd0[0], 32'hC0DE0040);
    chk("lit_lone_rdata", 1, rd0[1], 32'hC0DE0040);
    adv();

    // flush in the grant cycle kills p0's return, not the following p1 read
    setp0(1, 4'h0, 32'h108, 0); flush = 1'b1;
    mid();
    chk("lit_flush_gnt0", 0, g0[0], 1);
    adv();
    flush = 1'b0; setp0(0, 0, 0, 0); setp1(1, 4'h0, 32'h10C, 0);
    mid();
    chk("lit_killed_rvalid0", 0, v0[0], 0);
    chk("lit_killed_rvalid0", 1, v0[1], 0);
    adv();
    setp1(0, 0, 0, 0);
    mid();
    chk("lit_p1_after_flush", 0, v1[0], 1);
    chk("lit_p1_after_flush_data", 1, rd1[1], 32'hC0DE0043);
    adv();

    // flush in the return cycle
    setp0(1, 4'h0, 32'h110, 0);
    mid(); adv();
    setp0(0, 0, 0, 0); flush = 1'b1;
    mid();
    chk("lit_flush_ret_p0", 0, v0[0], 0);
    adv();
    flush = 1'b0; setp1(1, 4'h0, 32'h114, 0);
    mid(); adv();
    setp1(0, 0, 0, 0); flush = 1'b1;
    mid();
    chk("lit_flush_ret_p1", 1, v1[1], 1);
    chk("lit_flush_ret_p1_data", 0, rd1[0], 32'hC0DE0045);
    adv();
    flush = 1'b0;

    // p1 full-word write, then p0 reads it back
    setp1(1, 4'hF, 32'h200, 32'hDEADBEEF);
    mid();
    chk("lit_wr_gnt1", 0, g1[0], 1);
    chk("lit_wr_wen", 0, s_wen[0], 4'hF);
    chk("lit_wr_wdata", 1, s_wdata[1], 32'hDEADBEEF);
    adv();
    setp1(0, 0, 0, 0); setp0(1, 4'h0, 32'h200, 0);
    mid();
    chk("lit_wr_no_rvalid1", 0, v1[0], 0);
    chk("lit_wr_no_rvalid0", 1, v0[1], 0);
    adv();
    setp0(0, 0, 0, 0);
    mid();
    chk("lit_rdback", 0, rd0[0], 32'hDEADBEEF);
    chk("lit_rdback", 1, rd0[1], 32'hDEADBEEF);
    adv();

    // partial byte write: bytes 0 and 2 of word 0x81
    setp0(1, 4'b0101, 32'h204, 32'h11223344);
    mid(); adv();
    setp0(1, 4'h0, 32'h204, 0);
    mid(); adv();
    setp0(0, 0, 0, 0);
    mid();
    chk("lit_bytes", 0, rd0[0], 32'hC0220044);
    adv();

    // p1 drops its request before it is served on the fixed instance
    setp0(1, 4'h0, 32'h120, 0); setp1(1, 4'h0, 32'h124, 0);
    mid();
    chk("lit_drop_rr_gnt1", 0, g1[0], 1);
    chk("lit_drop_fx_gnt0", 1, g0[1], 1);
    adv();
    setp1(0, 0, 0, 0);
    mid(); adv();
    setp0(0, 0, 0, 0);
    mid(); adv();

    // reset right after a read grant: no return, pointer back to p0
    setp0(1, 4'h0, 32'h100, 0);
    mid(); adv();
    rst = 1'b0; setp1(1, 4'h0, 32'h104, 0);
    mid();
    chk("lit_rst_rvalid0", 0, v0[0], 0);
    chk("lit_rst_rvalid0", 1, v0[1], 0);
    chk("lit_rst_stall2", 0, stall[0], 0);
    adv();
    rst = 1'b1;
    mid();
    chk("lit_post_rst_gnt0", 0, g0[0], 1);
    chk("lit_post_rst_rvalid", 0, v0[0], 0);
    adv();
    setp0(0, 0, 0, 0); setp1(0, 0, 0, 0);
    mid(); adv();

    // mixed traffic from a fixed scramble of the cycle index
    for (int i = 0; i < 48; i++) begin
      h = 8'(i * 37 + 11);
      setp0(h[0], h[2] ? 4'hF : 4'h0, 32'h300 + 32'((i % 8) * 4), 32'h5A000000 | 32'(i));
      setp1(h[1], h[3] ? 4'b0011 : 4'h0, 32'h300 + 32'(((i + 3) % 8) * 4), 32'hA5000000 | 32'(i));
      flush = h[5] & h[4];
      mid(); adv();
    end
    setp0(0, 0, 0, 0); setp1(0, 0, 0, 0); flush = 1'b0;
    mid(); adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
